// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake carrying PC, instruction and payload.
// Define PIPE_SKID_REG_SKID_EN for the two-entry skid version with registered in_ready.

// state | meaning
// EMPTY | no entry held, outputs are a zero bubble
// ONE   | main entry valid and driving the outputs
// TWO   | main and skid entries valid, upstream stalled
module pipe_skid_reg #(
    parameter int PC_W      = 32,
    parameter int INSTR_W   = 32,
    parameter int PAYLOAD_W = 97
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state;
    logic [PC_W-1:0]        main_pc;
    logic [INSTR_W-1:0]     main_instr;
    logic [PAYLOAD_W-1:0]   main_payload;
    logic                   accept;
    logic                   drain;

`ifdef PIPE_SKID_REG_SKID_EN
    logic [PC_W-1:0]        skid_pc;
    logic [INSTR_W-1:0]     skid_instr;
    logic [PAYLOAD_W-1:0]   skid_payload;
    logic                   in_ready_q;

    assign in_ready = in_ready_q;
`else
    assign in_ready = (state == EMPTY) | out_ready;
`endif

    assign out_valid   = (state != EMPTY);
    assign accept      = in_valid & in_ready;
    assign drain       = out_valid & out_ready;
    assign count       = state;
    // Main fields are kept at zero whenever the stage is empty, so outputs are a bubble.
    assign out_pc      = main_pc;
    assign out_instr   = main_instr;
    assign out_payload = main_payload;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state        <= EMPTY;
            main_pc      <= '0;
            main_instr   <= '0;
            main_payload <= '0;
`ifdef PIPE_SKID_REG_SKID_EN
            skid_pc      <= '0;
            skid_instr   <= '0;
            skid_payload <= '0;
            in_ready_q   <= 1'b1;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_pc      <= in_pc;
                        main_instr   <= in_instr;
                        main_payload <= in_payload;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    if (drain) begin
                        if (accept) begin
                            main_pc      <= in_pc;
                            main_instr   <= in_instr;
                            main_payload <= in_payload;
                        end else begin
                            main_pc      <= '0;
                            main_instr   <= '0;
                            main_payload <= '0;
                            state        <= EMPTY;
                        end
                    end else if (accept) begin
`ifdef PIPE_SKID_REG_SKID_EN
                        skid_pc      <= in_pc;
                        skid_instr   <= in_instr;
                        skid_payload <= in_payload;
                        state        <= TWO;
                        in_ready_q   <= 1'b0;
`endif
                    end
                end
`ifdef PIPE_SKID_REG_SKID_EN
                TWO: begin
                    if (drain) begin
                        main_pc      <= skid_pc;
                        main_instr   <= skid_instr;
                        main_payload <= skid_payload;
                        skid_pc      <= '0;
                        skid_instr   <= '0;
                        skid_payload <= '0;
                        state        <= ONE;
                        in_ready_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios then randomized traffic,
// checked against a queue model of the stage occupancy (capacity 2 with skid, 1 without).
module tb_pipe_skid_reg;

    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int PAYLOAD_W = 97;
`ifdef PIPE_SKID_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [INSTR_W-1:0]   instr;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 reset, clear, in_valid, in_ready, out_valid, out_ready;
    logic [PC_W-1:0]      in_pc, out_pc;
    logic [INSTR_W-1:0]   in_instr, out_instr;
    logic [PAYLOAD_W-1:0] in_payload, out_payload;
    logic [1:0]           count;

    pipe_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_payload(out_payload),
        .count(count)
    );

    always #5 clk = ~clk;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   pend_acc = 1'b0, pend_drn = 1'b0, pend_clr = 1'b0, pend_chk = 1'b0;
    bit   exp_rdy  = 1'b1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus just after the rising edge and update the model.
    task automatic drive(input bit rst, input bit clr, input bit v, input logic [PC_W-1:0] pc,
                         input logic [INSTR_W-1:0] ins, input logic [PAYLOAD_W-1:0] pl,
                         input bit ordy);
        int   occ;
        ent_t e;
        @(posedge clk);
        #1;
        reset = rst; clear = clr; in_valid = v; in_pc = pc; in_instr = ins;
        in_payload = pl; out_ready = ordy;
        occ      = sb.size();
        exp_rdy  = SKID ? (occ < 2) : ((occ == 0) || ordy);
        pend_clr = rst | clr;
        pend_drn = (occ > 0) && ordy && !pend_clr;
        pend_acc = v && exp_rdy && !pend_clr;
        if (pend_acc) begin
            e.pc = pc; e.instr = ins; e.payload = pl;
            sb.push_back(e);
        end
    endtask

    // Monitor: compares what the DUT presents against the model, then retires entries.
    always @(negedge clk) begin
        int exp_occ;
        exp_occ = sb.size() - (pend_acc ? 1 : 0);
        if (pend_chk) begin
            check("out_valid", 128'(out_valid), 128'(exp_occ > 0));
            check("count", 128'(count), 128'(exp_occ));
            check("in_ready", 128'(in_ready), 128'(exp_rdy));
            if (exp_occ > 0) begin
                check("out_pc", 128'(out_pc), 128'(sb[0].pc));
                check("out_instr", 128'(out_instr), 128'(sb[0].instr));
                check("out_payload", 128'(out_payload), 128'(sb[0].payload));
            end else begin
                check("bubble_pc", 128'(out_pc), 128'(0));
                check("bubble_instr", 128'(out_instr), 128'(0));
                check("bubble_payload", 128'(out_payload), 128'(0));
            end
        end
        if (pend_clr) sb.delete();
        else if (pend_drn) void'(sb.pop_front());
    end

    initial begin
        logic [PAYLOAD_W-1:0] ones;
        logic [PAYLOAD_W-1:0] rpl;
        logic [127:0]         wide;
        ones = '1;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; in_payload = '0;

        // Reset with a live input that must be dropped.
        drive(1, 0, 1, 32'h0, 32'h8C080004, '0, 0);
        pend_chk = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, '0, 0);

        // Streaming
        drive(0, 0, 1, 32'h3000, 32'h00000001, 97'h11, 1);
        drive(0, 0, 1, 32'h3004, 32'h00000002, 97'h22, 1);
        drive(0, 0, 1, 32'h3008, 32'h00000003, 97'h33, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);

        // Skid fill then release
        drive(0, 0, 1, 32'h3000, 32'hAAAA0000, 97'h1, 1);
        drive(0, 0, 1, 32'h3004, 32'hAAAA0004, 97'h2, 0);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 0);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);

        // Clear while full, with a live input in the clear cycle
        drive(0, 0, 1, 32'h3000, 32'hBBBB0000, 97'h5, 0);
        drive(0, 0, 1, 32'h3004, 32'hBBBB0004, 97'h6, 0);
        drive(0, 1, 1, 32'h3008, 32'hBBBB0008, 97'h7, 0);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);

        // Drain to empty with an all-ones payload
        drive(0, 0, 1, 32'h3010, 32'hCCCC0010, ones, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            wide = {$urandom, $urandom, $urandom, $urandom};
            rpl  = wide[PAYLOAD_W-1:0];
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 99) < 65), $urandom, $urandom, rpl,
                  ($urandom_range(0, 99) < 60));
        end
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, '0, 1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register for the five-stage MIPS core, successor to the fixed-field inter-stage registers (E→M and siblings). It carries a PC, an instruction word and a generic payload bundle of configurable width, with valid/ready handshaking on both sides. A two-entry skid buffer lets the upstream stage see a registered `in_ready`, so stall paths never pass combinationally through the stage. It is instantiated between any two stages; flush and reset insert a zero bubble (`instr = 0`, i.e. `sll $0,$0,0`).

## Interface
- `PC_W`, 32, PC field width
- `INSTR_W`, 32, instruction field width
- `PAYLOAD_W`, 97, payload width (e.g. Grt + ALU result + imm32 + branch flag)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `clear`  in  1  synchronous flush, active-high
- `in_valid`  in  1  upstream entry present
- `in_ready`  out  1  stage can accept this cycle
- `in_pc` / `in_instr` / `in_payload`  in  PC_W / INSTR_W / PAYLOAD_W  upstream fields
- `out_valid`  out  1  downstream entry present
- `out_ready`  in  1  downstream accepts this cycle
- `out_pc` / `out_instr` / `out_payload`  out  PC_W / INSTR_W / PAYLOAD_W  downstream fields
- `count`  out  2  occupancy, 0..2

## Operation
- Storage: main entry (drives outputs) and skid entry. Accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- States: EMPTY (count 0), ONE (main valid), TWO (main and skid valid).
- EMPTY: accept → main ← in, go to ONE. `out_ready` ignored.
- ONE: accept and drain → main ← in, stay in ONE. Drain only → go to EMPTY. Accept only → skid ← in, go to TWO. Neither → hold.
- TWO: `in_ready = 0`. Drain → main ← skid, go to ONE, skid cleared to 0. No drain → hold.
- `in_ready` is a register output: `in_ready = (state != TWO)`.
- Bubble rule: whenever main is not valid, `out_pc`, `out_instr` and `out_payload` are all 0. Going to EMPTY zeroes the main fields in the same edge.
- Priority: `reset` > `clear` > handshake. `clear` empties both entries and zeroes all fields. An input presented in the `clear` cycle is dropped, even if `in_ready = 1`.
- Fields are copied unmodified, with no width conversion. Entry order is strictly FIFO.

## Timing
- Reset or clear values: `out_valid = 0`, `count = 0`, `in_ready = 1`, all data outputs 0.
- Latency: an accepted entry appears on the outputs on the next rising edge (1 cycle) when the stage was EMPTY, or when it was ONE with a drain in the same cycle.
- Throughput: 1 entry per cycle with `out_ready` held high.
- A downstream stall raised while in ONE absorbs exactly one extra entry. `in_ready` falls one cycle after the stall cycle.
- Reset or clear while in TWO loses both entries. No partial drain occurs.
- Simultaneous accept and drain in ONE never enters TWO.

## Configuration
- `PIPE_SKID_REG_SKID_EN` defined: two-entry behaviour as specified above. `in_ready` is registered and `count` ranges 0..2.
- Not defined: the skid entry and the TWO state are removed.
  - `in_ready = ~out_valid | out_ready`, which is combinational.
  - `count` ranges 0..1.
  - All other rules (bubble zeroing, clear priority, 1-cycle latency) are unchanged.

## Test plan
- Reset: assert `reset` for 1 cycle with `in_valid = 1`, `in_instr = 0x8C080004` → next cycle `out_valid = 0`, `out_instr = 0`, `count = 0`, `in_ready = 1`.
- Streaming: `out_ready = 1`, push PCs 0x3000, 0x3004 and 0x3008 on consecutive cycles → outputs show the same PCs, each one cycle later, with no gaps.
- Skid fill: in ONE holding 0x3000, drop `out_ready` and push 0x3004 → `count = 2` and `in_ready = 0`. Raise `out_ready` → 0x3000 drains, then 0x3004; `in_ready` returns to 1 after the first drain.
- Clear in TWO: assert `clear` with 0x3000/0x3004 held and `in_valid = 1`, PC 0x3008 → next cycle `count = 0`, all outputs 0, and 0x3008 never appears.
- Drain to empty: single entry 0x3010 with payload all ones, `out_ready = 1`, no new input → next cycle `out_valid = 0` and `out_payload = 0`.
- Macro off: repeat the skid-fill scenario → `in_ready` follows `out_ready` in the same cycle and `count` never exceeds 1.
